// File: rtl/vtx_stream_mgr.sv
// Object/vertex streamer: reads an object header into a flat parameter bus, then
// prefetches vertices from memory into a small FIFO delivered with valid/ready.
module vtx_stream_mgr #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 22,
   parameter int NUM_PARAMS = 16,
   parameter int VTX_COMP   = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                           iClock,
   input  logic                           iReset,
   input  logic                           iStart,
   input  logic [ADDR_W-1:0]              iBaseAddr,
   input  logic [CNT_W-1:0]               iVtxCount,
   output logic [ADDR_W-1:0]              oAddress,
   output logic                           oValidRequest,
   output logic                           oWrite,
   input  logic [DATA_W-1:0]              iData,
   input  logic                           iValidRead,
   output logic [NUM_PARAMS*DATA_W-1:0]   oParams,
   output logic                           oInitObj,
   output logic [VTX_COMP*DATA_W-1:0]     oVertex,
   output logic                           oVtxValid,
   input  logic                           iVtxReady,
   output logic                           oBusy,
   output logic                           oDone
);

   localparam int PIDX_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
   localparam int CIDX_W = (VTX_COMP > 1) ? $clog2(VTX_COMP) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = PTR_W + 1;
   localparam logic [PIDX_W-1:0] LAST_PARAM = PIDX_W'(NUM_PARAMS - 1);
   localparam logic [CIDX_W-1:0] LAST_COMP  = CIDX_W'(VTX_COMP - 1);
   localparam logic [FCNT_W-1:0] DEPTH      = FCNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, HDR_REQ, HDR_WAIT, VTX_REQ, VTX_WAIT, DRAIN, DONE} state_t;

   state_t                        state, state_n;
   logic [ADDR_W-1:0]             ptr;
   logic [CNT_W-1:0]              vtx_total, vtx_fetched;
   logic [PIDX_W-1:0]             param_idx;
   logic [CIDX_W-1:0]             comp_idx;
   logic [NUM_PARAMS*DATA_W-1:0]  shadow, shadow_n;
   logic [VTX_COMP*DATA_W-1:0]    stage, stage_n, head_n;
   logic [VTX_COMP*DATA_W-1:0]    fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]              wr_ptr, rd_ptr, rd_ptr_n;
   logic [FCNT_W-1:0]             fifo_cnt, fifo_cnt_n;
   logic                          start, issue, cap_hdr, cap_vtx, hdr_last, push, pop;

   assign oWrite   = 1'b0;
   assign hdr_last = cap_hdr && (param_idx == LAST_PARAM);
   assign push     = cap_vtx && (comp_idx == LAST_COMP);
   assign pop      = oVtxValid && iVtxReady;

   always_ff @(posedge iClock) begin
      if (iReset) state <= IDLE;
      else        state <= state_n;
   end

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_n = state;
      start   = 1'b0;
      issue   = 1'b0;
      cap_hdr = 1'b0;
      cap_vtx = 1'b0;
      case (state)
         IDLE:     if (iStart) begin
                      start   = 1'b1;
                      state_n = HDR_REQ;
                   end
         HDR_REQ:  begin
                      issue   = 1'b1;
                      state_n = HDR_WAIT;
                   end
         // The cycle oInitObj is high is spent here deciding where to go next.
         HDR_WAIT: if (oInitObj) begin
                      state_n = (vtx_total == '0) ? DONE : VTX_REQ;
                   end else if (iValidRead) begin
                      cap_hdr = 1'b1;
                      if (param_idx != LAST_PARAM) state_n = HDR_REQ;
                   end
         VTX_REQ:  if (fifo_cnt < DEPTH) begin
                      issue   = 1'b1;
                      state_n = VTX_WAIT;
                   end
         VTX_WAIT: if (iValidRead) begin
                      cap_vtx = 1'b1;
                      if (comp_idx == LAST_COMP && vtx_fetched + CNT_W'(1) == vtx_total)
                         state_n = DRAIN;
                      else
                         state_n = VTX_REQ;
                   end
         DRAIN:    if (fifo_cnt == '0) state_n = DONE;
         DONE:     state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end

   always_comb begin
      shadow_n = shadow;
      shadow_n[param_idx*DATA_W +: DATA_W] = iData;
      stage_n  = stage;
      stage_n[comp_idx*DATA_W +: DATA_W] = iData;
      fifo_cnt_n = fifo_cnt + FCNT_W'(push) - FCNT_W'(pop);
      rd_ptr_n   = rd_ptr + PTR_W'(pop);
      // Bypass when the entry being pushed becomes the head in the same edge.
      head_n = (push && fifo_cnt == FCNT_W'(pop)) ? stage_n : fifo_mem[rd_ptr_n];
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         ptr           <= '0;
         oAddress      <= '0;
         oValidRequest <= 1'b0;
         vtx_total     <= '0;
         vtx_fetched   <= '0;
         param_idx     <= '0;
         comp_idx      <= '0;
         shadow        <= '0;
         oParams       <= '0;
         oInitObj      <= 1'b0;
         stage         <= '0;
         oBusy         <= 1'b0;
         oDone         <= 1'b0;
      end else begin
         oValidRequest <= issue;
         oInitObj      <= hdr_last;
         oDone         <= (state == DONE);
         if (start) begin
            ptr         <= iBaseAddr;
            vtx_total   <= iVtxCount;
            vtx_fetched <= '0;
            param_idx   <= '0;
            comp_idx    <= '0;
            oBusy       <= 1'b1;
         end
         if (state == DONE) oBusy <= 1'b0;
         if (issue) begin
            oAddress <= ptr;
            ptr      <= ptr + 1'b1;
         end
         if (cap_hdr) begin
            shadow    <= shadow_n;
            param_idx <= hdr_last ? '0 : param_idx + 1'b1;
         end
         if (hdr_last) oParams <= shadow_n;
         if (cap_vtx) begin
            stage    <= stage_n;
            comp_idx <= push ? '0 : comp_idx + 1'b1;
         end
         if (push) vtx_fetched <= vtx_fetched + 1'b1;
      end
   end

   // NOTE: the FIFO storage is not reset; the pointers and count alone define which entries are live.
   always_ff @(posedge iClock) begin
      if (push) fifo_mem[wr_ptr] <= stage_n;
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_cnt  <= '0;
         oVtxValid <= 1'b0;
         oVertex   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr    <= rd_ptr_n;
         fifo_cnt  <= fifo_cnt_n;
         oVtxValid <= (fifo_cnt_n != '0);
         if (fifo_cnt_n != '0) oVertex <= head_n;
      end
   end

endmodule

// File: tb/tb_vtx_stream_mgr.sv
// Self-checking bench for vtx_stream_mgr: a memory model answering requests with addr[15:0]
// and an address-arithmetic reference for the header and vertex streams.
module tb_vtx_stream_mgr;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 22;
   localparam int NUM_PARAMS = 16;
   localparam int VTX_COMP   = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 16;

   typedef logic [NUM_PARAMS*DATA_W-1:0] val_t;

   logic                          clk = 1'b0;
   logic                          iReset, iStart, iValidRead, iVtxReady;
   logic [ADDR_W-1:0]             iBaseAddr;
   logic [CNT_W-1:0]              iVtxCount;
   logic [DATA_W-1:0]             iData;
   logic [ADDR_W-1:0]             oAddress;
   logic                          oValidRequest, oWrite, oInitObj, oVtxValid, oBusy, oDone;
   logic [NUM_PARAMS*DATA_W-1:0]  oParams;
   logic [VTX_COMP*DATA_W-1:0]    oVertex;

   always #5 clk = ~clk;

   vtx_stream_mgr #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PARAMS(NUM_PARAMS),
      .VTX_COMP(VTX_COMP), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .iClock(clk), .iReset(iReset), .iStart(iStart), .iBaseAddr(iBaseAddr),
      .iVtxCount(iVtxCount), .oAddress(oAddress), .oValidRequest(oValidRequest),
      .oWrite(oWrite), .iData(iData), .iValidRead(iValidRead), .oParams(oParams),
      .oInitObj(oInitObj), .oVertex(oVertex), .oVtxValid(oVtxValid),
      .iVtxReady(iVtxReady), .oBusy(oBusy), .oDone(oDone)
   );

   int                checks = 0, errors = 0, cyc = 0;
   logic [ADDR_W-1:0] obj_base;
   int                obj_count, req_idx, vtx_idx, init_cnt, done_cnt, init_cyc, done_cyc;
   int                rsp_cnt, ready_mode;
   bit                outstanding, slow, spurious, noise, valid_seen, hit;
   logic [DATA_W-1:0] rsp_data;

   task automatic check(input string tag, input val_t obs, input val_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: memory model, output monitor and ready/noise drivers, all at the falling edge.
   task automatic tick();
      bit                drove;
      logic [ADDR_W-1:0] a;
      val_t              exp_v;
      @(negedge clk);
      cyc++;
      drove      = 1'b0;
      iValidRead = 1'b0;
      iData      = DATA_W'($urandom);
      if (rsp_cnt != 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            drove      = 1'b1;
            iValidRead = 1'b1;
            iData      = rsp_data;
         end
      end
      if (!drove && spurious && !oBusy) iValidRead = 1'($urandom_range(1, 0));
      if (oValidRequest) begin
         check("one_outstanding", val_t'(outstanding), val_t'(0));
         check("write_low", val_t'(oWrite), val_t'(0));
         a = obj_base + ADDR_W'(req_idx);
         check("req_addr", val_t'(oAddress), val_t'(a));
         rsp_data = oAddress[DATA_W-1:0];
         rsp_cnt  = slow ? int'($urandom_range(8, 1)) : 1;
         req_idx++;
      end
      if (drove) outstanding = 1'b0;
      if (oValidRequest) outstanding = 1'b1;

      if (oInitObj) begin
         init_cnt++;
         init_cyc = cyc;
         exp_v = '0;
         for (int k = 0; k < NUM_PARAMS; k++) begin
            a = obj_base + ADDR_W'(k);
            exp_v[k*DATA_W +: DATA_W] = a[DATA_W-1:0];
         end
         check("params", oParams, exp_v);
      end
      if (oDone) begin
         done_cnt++;
         done_cyc = cyc;
         check("busy_low_at_done", val_t'(oBusy), val_t'(0));
      end
      if (oVtxValid) valid_seen = 1'b1;

      case (ready_mode)
         0:       iVtxReady = 1'b0;
         1:       iVtxReady = 1'b1;
         default: iVtxReady = 1'($urandom_range(1, 0));
      endcase
      if (oVtxValid && iVtxReady) begin
         check("vtx_in_range", val_t'(vtx_idx < obj_count), val_t'(1));
         exp_v = '0;
         for (int c = 0; c < VTX_COMP; c++) begin
            a = obj_base + ADDR_W'(NUM_PARAMS + VTX_COMP*vtx_idx + c);
            exp_v[c*DATA_W +: DATA_W] = a[DATA_W-1:0];
         end
         check("vertex", val_t'(oVertex), exp_v);
         vtx_idx++;
      end

      iStart = 1'b0;
      if (noise && oBusy && $urandom_range(3, 0) == 0) begin
         iStart    = 1'b1;
         iBaseAddr = ADDR_W'($urandom);
         iVtxCount = CNT_W'($urandom_range(20, 0));
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_address", val_t'(oAddress), '0);
      check("rst_request", val_t'(oValidRequest), '0);
      check("rst_write", val_t'(oWrite), '0);
      check("rst_params", oParams, '0);
      check("rst_init", val_t'(oInitObj), '0);
      check("rst_vertex", val_t'(oVertex), '0);
      check("rst_vtx_valid", val_t'(oVtxValid), '0);
      check("rst_busy", val_t'(oBusy), '0);
      check("rst_done", val_t'(oDone), '0);
   endtask

   task automatic start_obj(input logic [ADDR_W-1:0] base, input int count);
      obj_base   = base;
      obj_count  = count;
      req_idx    = 0;
      vtx_idx    = 0;
      init_cnt   = 0;
      done_cnt   = 0;
      valid_seen = 1'b0;
      iStart     = 1'b1;
      iBaseAddr  = base;
      iVtxCount  = CNT_W'(count);
      tick();
      check("busy_after_start", val_t'(oBusy), val_t'(1));
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      check("done_within_budget", val_t'(done_cnt != 0), val_t'(1));
      if (done_cnt == 0) begin
         iReset = 1'b1;
         tick();
         iReset      = 1'b0;
         rsp_cnt     = 0;
         outstanding = 1'b0;
      end
   endtask

   task automatic end_obj();
      tick();
      check("done_once", val_t'(done_cnt), val_t'(1));
      check("busy_after_done", val_t'(oBusy), val_t'(0));
      check("req_count", val_t'(req_idx), val_t'(NUM_PARAMS + VTX_COMP*obj_count));
      check("vtx_count", val_t'(vtx_idx), val_t'(obj_count));
      check("init_once", val_t'(init_cnt), val_t'(1));
   endtask

   task automatic run_object(input logic [ADDR_W-1:0] base, input int count);
      start_obj(base, count);
      wait_done(3000);
      end_obj();
   endtask

   initial begin
      iReset = 1'b1; iStart = 1'b0; iValidRead = 1'b0; iVtxReady = 1'b0;
      iBaseAddr = '0; iVtxCount = '0; iData = '0;
      obj_base = '0; obj_count = 0; req_idx = 0; vtx_idx = 0;
      init_cnt = 0; done_cnt = 0; init_cyc = 0; done_cyc = 0; rsp_cnt = 0;
      outstanding = 1'b0; slow = 1'b0; spurious = 1'b0; noise = 1'b0;
      valid_seen = 1'b0; hit = 1'b0; ready_mode = 1; rsp_data = '0;

      tick();
      tick();
      check_reset_outputs();
      iReset = 1'b0;
      tick();

      // Basic two-vertex object with single-cycle memory.
      run_object(22'h000100, 2);

      // Empty object: header only, done two cycles after init.
      run_object(22'h000200, 0);
      check("done_2_after_init", val_t'(done_cyc - init_cyc), val_t'(2));
      check("no_vtx_valid", val_t'(valid_seen), val_t'(0));

      // Backpressure: FIFO fills, fetching stalls, then drains in order.
      ready_mode = 0;
      start_obj(22'h001000, 10);
      for (int i = 0; i < 200; i++) tick();
      check("stall_req_count", val_t'(req_idx), val_t'(NUM_PARAMS + VTX_COMP*FIFO_DEPTH));
      check("stall_vtx_valid", val_t'(oVtxValid), val_t'(1));
      check("stall_no_pop", val_t'(vtx_idx), val_t'(0));
      ready_mode = 1;
      wait_done(3000);
      end_obj();

      // Address wrap across the top of memory.
      run_object(22'h3FFFF8, 1);

      // Reset while waiting on a vertex read; the stale response must be ignored.
      slow = 1'b1;
      start_obj(22'h002000, 5);
      hit = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         tick();
         if (oValidRequest && req_idx > NUM_PARAMS + VTX_COMP) hit = 1'b1;
      end
      check("reached_vtx_wait", val_t'(hit), val_t'(1));
      iReset = 1'b1;
      tick();
      check_reset_outputs();
      iReset      = 1'b0;
      outstanding = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check("idle_after_reset", val_t'(oBusy | oValidRequest | oInitObj), val_t'(0));
      run_object(22'h002000, 5);

      // Randomised objects: random latency and ready, busy-time start noise, idle read noise.
      ready_mode = 2;
      for (int o = 0; o < 50; o++) begin
         spurious = 1'b1;
         noise    = 1'b0;
         for (int i = 0; i < 3; i++) tick();
         spurious = 1'b0;
         check("idle_ignores_reads", val_t'(oBusy | oValidRequest | oInitObj), val_t'(0));
         noise = 1'b1;
         run_object(ADDR_W'($urandom), int'($urandom_range(6, 0)));
      end
      noise = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vtx_stream_mgr.md
Name: vtx_stream_mgr

Overview:
- Parametrised object and vertex streamer between the SRAM request interface and the graphics pipeline.
- On a start command it fetches one object header (NUM_PARAMS words) from memory and presents it as a flat parameter bus with an init pulse.
- It then prefetches iVtxCount vertices (VTX_COMP words each) into a FIFO and delivers them with a valid/ready handshake.
- Generalises the fixed 16-bit camera/transform/vertex outputs to configurable width, parameter count and vertex arity, and adds backpressure buffering.

Parameters:
DATA_W, 16, width of one memory word, parameter and vertex component
ADDR_W, 22, memory word address width
NUM_PARAMS, 16, header words per object (cam X/Y/Z/Dc, cos x3, sin x3, scale x3, transl x3)
VTX_COMP, 3, components per vertex
FIFO_DEPTH, 4, vertex FIFO entries (power of two, >=2)
CNT_W, 16, width of vertex count

Ports:
iClock  in  1  system clock
iReset  in  1  synchronous, active-high reset
iStart  in  1  start-object pulse; sampled only in IDLE
iBaseAddr  in  ADDR_W  address of header word 0; sampled with iStart
iVtxCount  in  CNT_W  vertices in object; sampled with iStart
oAddress  out  ADDR_W  memory read address
oValidRequest  out  1  one-cycle read request
oWrite  out  1  tied 0 (read-only block)
iData  in  DATA_W  read data
iValidRead  in  1  read data valid, one cycle
oParams  out  NUM_PARAMS*DATA_W  header words; word k at bits [k*DATA_W +: DATA_W]
oInitObj  out  1  one-cycle pulse: oParams updated
oVertex  out  VTX_COMP*DATA_W  FIFO head vertex; component c at [c*DATA_W +: DATA_W]
oVtxValid  out  1  FIFO not empty
iVtxReady  in  1  pipeline accepts vertex when oVtxValid && iVtxReady
oBusy  out  1  high from accepted iStart until oDone
oDone  out  1  one-cycle pulse: object complete

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, counters 0. Applies mid-operation. An iValidRead arriving after reset is ignored.
- Only one read is outstanding at a time. A request is oValidRequest=1 for exactly one cycle with a stable oAddress. The block then waits in a *_WAIT state until iValidRead and captures iData. The next request may issue the cycle after capture.
- iValidRead outside a *_WAIT state is ignored.
- Addresses are sequential from iBaseAddr: header words first, then vertex components. Address arithmetic is modulo 2^ADDR_W (wrap allowed).
- FSM states: IDLE, HDR_REQ, HDR_WAIT, VTX_REQ, VTX_WAIT, DRAIN, DONE.
- IDLE: when iStart=1, latch base address and count, set oBusy=1, go to HDR_REQ. iStart while busy is ignored.
- HDR_REQ -> HDR_WAIT. Each captured header word goes to a shadow register.
- After the NUM_PARAMS-th word, the shadow copies into oParams and oInitObj=1 on the next cycle. oParams holds until the next object's header completes.
- Same cycle as oInitObj: if count=0 go to DONE, else go to VTX_REQ.
- VTX_REQ: issues a request only if FIFO count < FIFO_DEPTH (a pop in the same cycle does not count toward space). Otherwise it stalls in VTX_REQ.
- VTX_WAIT: components fill a staging register in order 0..VTX_COMP-1.
- On the last component, the staged vertex pushes into the FIFO next cycle. Overflow is impossible by construction.
- After the iVtxCount-th vertex is fetched go to DRAIN, else go to VTX_REQ.
- DRAIN: wait until the FIFO is empty, then go to DONE.
- DONE: oDone=1 for one cycle, oBusy=0, go to IDLE.
- Simultaneous FIFO push and pop: count is unchanged and both take effect.
- oVertex and oVtxValid are registered from the FIFO head. A popped entry is replaced the following cycle.
- Vertex order out equals memory order. No vertex is lost or duplicated under any iVtxReady pattern.

Test Plan:
- Defaults: iStart, base=0x000100, count=2, memory returns addr[15:0] after 1 cycle -> requests at 0x100..0x115. oParams word k=0x100+k. oInitObj pulses once. Vertices {0x110,0x111,0x112} and {0x113,0x114,0x115} out in order. oDone pulses, oBusy falls.
- count=0 -> 16 requests, oInitObj, then oDone 2 cycles later. oVtxValid never asserts.
- iVtxReady=0, count=10 -> fetching stalls after 4 vertices in the FIFO. Exactly 12 vertex requests are issued. Releasing ready yields all 10 in order.
- Base=0x3FFFF8, count=1 -> addresses wrap to 0x000000 after 0x3FFFFF. 19 total requests.
- Random iValidRead latency 1-8 cycles, random iVtxReady, 50 objects -> scoreboard matches. iStart pulses while busy are ignored. Spurious iValidRead in IDLE is ignored.
- iReset asserted mid-VTX_WAIT -> next cycle all outputs 0. A following iStart runs a full object correctly.
